// File: rtl/regchain_ctrl_if.sv
// Host-side word interface of the scan-chain sequencer:
// load handshake, readback pulse and busy flag.
interface regchain_ctrl_if #(
  parameter int W = 16
);
  logic         wr_valid;
  logic         wr_ready;
  logic [W-1:0] wr_data;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         busy;

  modport master (
    output wr_valid,
    output wr_data,
    input  wr_ready,
    input  rd_valid,
    input  rd_data,
    input  busy
  );

  modport slave (
    input  wr_valid,
    input  wr_data,
    output wr_ready,
    output rd_valid,
    output rd_data,
    output busy
  );
endinterface

// File: rtl/regchain_ctrl.sv
// Scan-chain sequencer: shifts a word MSB-first into the chain,
// pulses update, and returns the old chain contents as a word.
module regchain_ctrl #(
  parameter int CHAIN_LEN     = 16,
  parameter int UPDATE_CYCLES = 1,
  parameter int CNT_W         = 5
) (
  input  logic           clk,
  input  logic           reset,
  regchain_ctrl_if.slave host,
  output logic           chain_data,
  output logic           chain_enable,
  output logic           chain_update,
  input  logic           chain_return
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    UPDATE,
    SETTLE,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] SHIFT_LAST =
    CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] UPD_LAST =
    CNT_W'(UPDATE_CYCLES - 1);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_nx;
  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN-1:0] sr_nx;
  logic [CHAIN_LEN-1:0] rd_q;
  logic [CHAIN_LEN-1:0] rd_nx;
  logic                 rdy_q;
  logic                 rdy_nx;
  logic                 rv_q;
  logic                 rv_nx;
  logic                 busy_q;
  logic                 busy_nx;
  logic                 cd_q;
  logic                 cd_nx;
  logic                 en_q;
  logic                 en_nx;
  logic                 upd_q;
  logic                 upd_nx;
  logic                 accept;

  assign accept = host.wr_valid && rdy_q;

  assign host.wr_ready = rdy_q;
  assign host.rd_valid = rv_q;
  assign host.rd_data  = rd_q;
  assign host.busy     = busy_q;
  assign chain_data    = cd_q;
  assign chain_enable  = en_q;
  assign chain_update  = upd_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      sr     <= '0;
      rd_q   <= '0;
      rdy_q  <= 1'b0;
      rv_q   <= 1'b0;
      busy_q <= 1'b0;
      cd_q   <= 1'b0;
      en_q   <= 1'b0;
      upd_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      sr     <= sr_nx;
      rd_q   <= rd_nx;
      rdy_q  <= rdy_nx;
      rv_q   <= rv_nx;
      busy_q <= busy_nx;
      cd_q   <= cd_nx;
      en_q   <= en_nx;
      upd_q  <= upd_nx;
    end
  end

  // Every output is registered from its next value, so the
  // update line (a clock to the cells) can never glitch.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    sr_nx    = sr;
    rd_nx    = rd_q;
    rdy_nx   = 1'b0;
    rv_nx    = 1'b0;
    cd_nx    = 1'b0;
    en_nx    = 1'b0;
    upd_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nx = SHIFT;
          sr_nx    = host.wr_data;
          cnt_nx   = '0;
          en_nx    = 1'b1;
          cd_nx    = host.wr_data[CHAIN_LEN-1];
        end else begin
          rdy_nx = 1'b1;
        end
      end
      SHIFT: begin
        sr_nx  = {sr[CHAIN_LEN-2:0], chain_return};
        cnt_nx = cnt + 1'b1;
        if (cnt == SHIFT_LAST) begin
          state_nx = UPDATE;
          cnt_nx   = '0;
          upd_nx   = 1'b1;
        end else begin
          en_nx = 1'b1;
          cd_nx = sr[CHAIN_LEN-2];
        end
      end
      UPDATE: begin
        cnt_nx = cnt + 1'b1;
        if (cnt == UPD_LAST) begin
          state_nx = SETTLE;
          cnt_nx   = '0;
        end else begin
          upd_nx = 1'b1;
        end
      end
      SETTLE: begin
        rd_nx    = sr;
        rv_nx    = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        state_nx = IDLE;
        rdy_nx   = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_regchain_ctrl.sv
// Directed bench for regchain_ctrl: two instances (update width 1
// and 3), each driving a behavioural 8-cell scan chain.
module tb_regchain_ctrl;

  localparam int N = 8;

  typedef struct packed {
    int en;
    int upd;
    int rv;
    int ovl;
    int rbv;
  } mon_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]        wr_valid;
  logic [N-1:0]      wr_data [2];
  logic [1:0]        wr_ready;
  logic [1:0]        rd_valid;
  logic [1:0]        busy;
  logic [1:0][N-1:0] rd_data;
  logic [1:0]        cd;
  logic [1:0]        en;
  logic [1:0]        upd;
  logic [1:0]        ret;
  logic [1:0][N-1:0] bit_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : u
    regchain_ctrl_if #(.W(N)) bus ();

    assign bus.wr_valid = wr_valid[g];
    assign bus.wr_data  = wr_data[g];
    assign wr_ready[g]  = bus.wr_ready;
    assign rd_valid[g]  = bus.rd_valid;
    assign rd_data[g]   = bus.rd_data;
    assign busy[g]      = bus.busy;

    regchain_ctrl #(
      .CHAIN_LEN    (N),
      .UPDATE_CYCLES(g == 1 ? 3 : 1),
      .CNT_W        (5)
    ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .host        (bus),
      .chain_data  (cd[g]),
      .chain_enable(en[g]),
      .chain_update(upd[g]),
      .chain_return(ret[g])
    );

    // Cells capture on the rising edge, drive chain_out from the
    // falling edge, and load bit_out when the update pulse ends.
    logic [N-1:0] cap  = '0;
    logic [N-1:0] outr = '0;
    logic [N-1:0] bo   = '0;
    mon_t         m    = '0;

    always @(posedge clk) if (en[g]) cap <= {outr[N-2:0], cd[g]};
    always @(negedge clk) outr <= cap;
    always @(negedge upd[g]) bo <= cap;
    assign ret[g]     = outr[N-1];
    assign bit_out[g] = bo;

    always @(negedge clk) begin
      if (en[g]) m.en <= m.en + 1;
      if (upd[g]) m.upd <= m.upd + 1;
      if (rd_valid[g]) m.rv <= m.rv + 1;
      if (en[g] && upd[g]) m.ovl <= m.ovl + 1;
      if (busy[g] && wr_ready[g]) m.rbv <= m.rbv + 1;
    end
  end

  function automatic mon_t get_mon(input int g);
    return (g == 1) ? u[1].m : u[0].m;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_write(input int g, input logic [N-1:0] d);
    bit ok;
    ok = 1'b0;
    wr_data[g]  = d;
    wr_valid[g] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (wr_ready[g]) begin
        ok = 1'b1;
        break;
      end
    end
    check("acc_timeout", 32'(ok), 1);
    @(posedge clk);
    #1;
    wr_valid[g] = 1'b0;
    wr_data[g]  = ~d;
  endtask

  task automatic wait_done(input int g, output int lat);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      if (rd_valid[g]) break;
    end
    check("done_timeout", 32'(rd_valid[g]), 1);
    @(posedge clk);
    #1;
  endtask

  mon_t         s0;
  mon_t         s1;
  int           lat;
  int           nacc;
  int           last_c;
  logic [N-1:0] accw;
  logic [N-1:0] pat [5];

  initial begin
    wr_valid   = '0;
    wr_data[0] = '0;
    wr_data[1] = '0;

    #1;
    check("rst_outs0", {wr_ready[0], rd_valid[0], busy[0],
                        cd[0], en[0], upd[0]}, 0);
    check("rst_rd0", rd_data[0], 0);
    check("rst_outs1", {wr_ready[1], rd_valid[1], busy[1],
                        cd[1], en[1], upd[1]}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rdy_pre", 32'(wr_ready[0]), 0);
    @(posedge clk);
    #1;
    check("rdy_post", 32'(wr_ready[0]), 1);

    // 1: first load into an all-zero chain
    s0 = get_mon(0);
    start_write(0, 8'hA5);
    wait_done(0, lat);
    s1 = get_mon(0);
    check("t1_en_len", s1.en - s0.en, 8);
    check("t1_upd_len", s1.upd - s0.upd, 1);
    check("t1_cells", bit_out[0], 8'hA5);
    check("t1_lat", lat - 1, 10);
    check("t1_rd", rd_data[0], 8'h00);

    // 2: follow-up load returns the previous word
    s0 = get_mon(0);
    start_write(0, 8'h3C);
    wait_done(0, lat);
    s1 = get_mon(0);
    check("t2_cells", bit_out[0], 8'h3C);
    check("t2_rd", rd_data[0], 8'hA5);
    check("t2_rv_len", s1.rv - s0.rv, 1);
    check("t2_rdy_busy", s1.rbv - s0.rbv, 0);

    // 3: valid held high, data churns while busy
    s0 = get_mon(0);
    nacc   = 0;
    last_c = 0;
    accw   = '0;
    wr_data[0]  = 8'h11;
    wr_valid[0] = 1'b1;
    for (int c = 0; c < 100 && nacc < 3; c++) begin
      @(negedge clk);
      if (rd_valid[0]) check("t3_cells", bit_out[0], accw);
      if (wr_ready[0]) begin
        if (nacc > 0) check("t3_space", c - last_c, 12);
        accw   = wr_data[0];
        last_c = c;
        nacc++;
      end else begin
        wr_data[0] = wr_data[0] + 8'h27;
      end
    end
    check("t3_nacc", nacc, 3);
    @(posedge clk);
    #1 wr_valid[0] = 1'b0;
    wait_done(0, lat);
    s1 = get_mon(0);
    check("t3_cells_last", bit_out[0], accw);
    check("t3_rv_cnt", s1.rv - s0.rv, 3);
    check("t3_en_cnt", s1.en - s0.en, 24);

    // 4: three-cycle update pulse
    s0 = get_mon(1);
    start_write(1, 8'hFF);
    wait_done(1, lat);
    s1 = get_mon(1);
    check("t4_upd_len", s1.upd - s0.upd, 3);
    check("t4_overlap", s1.ovl - s0.ovl, 0);
    check("t4_en_len", s1.en - s0.en, 8);
    check("t4_lat", lat - 1, 12);
    check("t4_cells", bit_out[1], 8'hFF);
    check("t4_rd", rd_data[1], 8'h00);

    // 5: reset during shift cycle 4
    s0 = get_mon(0);
    start_write(0, 8'h81);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_outs", {wr_ready[0], rd_valid[0], busy[0],
                      cd[0], en[0], upd[0]}, 0);
    check("t5_rd", rd_data[0], 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("t5_rdy_pre", 32'(wr_ready[0]), 0);
    @(posedge clk);
    #1;
    check("t5_rdy_post", 32'(wr_ready[0]), 1);
    repeat (14) @(posedge clk);
    #1;
    s1 = get_mon(0);
    check("t5_no_upd", s1.upd - s0.upd, 0);
    check("t5_no_rv", s1.rv - s0.rv, 0);
    start_write(0, 8'h81);
    wait_done(0, lat);
    check("t5_cells", bit_out[0], 8'h81);

    // 6: readback bit order across patterns
    pat[0] = 8'h81;
    pat[1] = 8'h55;
    pat[2] = 8'hAA;
    pat[3] = 8'h01;
    pat[4] = 8'h80;
    for (int i = 1; i < 5; i++) begin
      start_write(0, pat[i]);
      wait_done(0, lat);
      check("t6_cells", bit_out[0], pat[i]);
      check("t6_rd", rd_data[0], pat[i-1]);
    end
    accw = pat[4];
    start_write(0, 8'h00);
    wait_done(0, lat);
    check("t6_rd_b0", 32'(rd_data[0][0]), 32'(accw[0]));
    check("t6_rd_b7", 32'(rd_data[0][7]), 32'(accw[7]));

    s0 = get_mon(0);
    s1 = get_mon(1);
    check("ovl_dut0", s0.ovl, 0);
    check("ovl_dut1", s1.ovl, 0);
    check("rdy_busy_dut0", s0.rbv, 0);
    check("rdy_busy_dut1", s1.rbv, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regchain_ctrl.md
Name: regchain_ctrl

Overview:
Sequencer for a daisy-chain of `register_cell`-style scan cells. It accepts a parallel configuration word over a valid/ready handshake and shifts it serially into the chain. It then issues a clean update pulse so that every cell's `bit_out` loads the new value. While shifting, it captures the bits returning from the chain's tail and presents the previous chain contents as a parallel readback word. It sits between the host/config logic and the first and last cells of the chain.

Parameters:
- CHAIN_LEN, default 16, number of cells in the chain and width of the word interfaces; must be >= 2.
- UPDATE_CYCLES, default 1, number of clk cycles `chain_update` is held high; must be >= 1.
- CNT_W, default 5, counter width; must satisfy 2^CNT_W > max(CHAIN_LEN, UPDATE_CYCLES).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- wr_valid  in  1  host presents a word to load.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  CHAIN_LEN  word to load; bit i is destined for cell i (cell 0 is nearest the controller).
- rd_valid  out  1  one-cycle pulse; `rd_data` holds the previous chain contents.
- rd_data  out  CHAIN_LEN  readback; bit i is the old content of cell i.
- busy  out  1  high whenever the controller is not IDLE.
- chain_data  out  1  drives `chain_in` of cell 0.
- chain_enable  out  1  drives `enable` of all cells (1 = shift, 0 = hold).
- chain_update  out  1  drives `update` of all cells.
- chain_return  in  1  `chain_out` of cell CHAIN_LEN-1.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - wr_ready=0, rd_valid=0, busy=0, chain_data=0, chain_enable=0, chain_update=0.
  - rd_data=0, shift register=0, counter=0.
  - The first cycle after reset release, wr_ready rises to 1.
- Outputs: all are driven directly from flops, so they are glitch-free. This is mandatory for `chain_update`, which is a clock to the cells.
- State machine:
  - IDLE:
    - wr_ready=1.
    - On wr_valid && wr_ready at edge E0: sr <= wr_data, cnt <= 0, go to SHIFT.
  - SHIFT (exactly CHAIN_LEN cycles, E0..E(N)):
    - chain_enable=1; chain_data = sr[CHAIN_LEN-1].
    - At each rising edge: sr <= {sr[CHAIN_LEN-2:0], chain_return}, cnt++.
    - After CHAIN_LEN edges, go to UPDATE.
    - chain_return is sampled at the same edge at which the cells shift. The cell tail updates on the falling edge, so it is stable at the sampling edge.
  - UPDATE (UPDATE_CYCLES cycles):
    - chain_enable=0, chain_update=1, chain_data=0.
    - Then go to SETTLE.
  - SETTLE (1 cycle):
    - All chain outputs 0.
    - rd_data <= sr; go to DONE.
  - DONE (1 cycle):
    - rd_valid=1, wr_ready=0.
    - Then go to IDLE.
- Word mapping: after SHIFT, cell i holds wr_data[i]; MSB is sent first. After SHIFT, sr[i] equals the old content of cell i.
- Latency:
  - Accept at E0.
  - chain_enable is high for exactly CHAIN_LEN cycles.
  - chain_update rises at E(N) and falls at E(N+U).
  - rd_valid is high from E(N+U+1) to E(N+U+2).
  - wr_ready returns at E(N+U+2).
  - Next accept is possible at E(N+U+3).
- Handshake:
  - wr_valid while wr_ready=0 is ignored.
  - The host must hold wr_valid and wr_data until accepted.
  - wr_data changes after acceptance do not affect the operation in flight.
- rd_data holds its value until the next SETTLE.
- busy = (state != IDLE).
- Reset mid-operation:
  - Outputs return immediately to their reset values; any pulse in flight is cut.
  - Chain cell contents are then undefined; no partial rd_valid is generated.
- chain_update is never high in the same cycle as chain_enable.

Test Plan:
1. CHAIN_LEN=8, UPDATE_CYCLES=1, behavioural 8-cell chain. Reset, then write 0xA5.
   - chain_enable is high for exactly 8 cycles.
   - chain_update pulse is 1 cycle wide.
   - Cell bit_outs read 0xA5.
   - rd_valid occurs 10 edges after acceptance.
2. Follow-up write of 0x3C.
   - Cells read 0x3C.
   - rd_data=0xA5.
   - rd_valid is exactly one cycle.
   - wr_ready is low from acceptance through DONE.
3. Hold wr_valid high continuously with a changing wr_data during busy.
   - Only one word is accepted per operation.
   - Consecutive acceptances are spaced CHAIN_LEN+UPDATE_CYCLES+3 cycles apart.
   - Cell contents match the words captured at acceptance.
4. UPDATE_CYCLES=3: write 0xFF.
   - chain_update is high for 3 cycles.
   - chain_enable=0 throughout.
   - rd_valid occurs at edge 8+3+1 after acceptance.
5. Assert reset at SHIFT cycle 4 with 0x81 in flight.
   - All outputs go to 0 asynchronously.
   - No chain_update and no rd_valid occur.
   - wr_ready=1 one cycle after reset release.
   - A subsequent write of 0x81 loads correctly.
6. Preload the chain with alternating 0/1 patterns at different word values.
   - Verify rd_data[i] equals the old cell i for every i, checking both bit-order endpoints (bit 0 and bit 7).
